fetch_queue: RTL

- Instruction fetch front-end that sits directly upstream of the decode/control stage.
- Generates sequential PCs and issues read requests to instruction memory over a valid/ready interface.
- Buffers returned instructions, each paired with its PC, in a small FIFO and presents them to decode over a valid/ready handshake.
- A taken branch or jump from execute redirects the PC, flushes the buffer and discards in-flight memory responses.

---
 rtl/fetch_queue.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: sequential-PC instruction fetch with a credit-limited
// response FIFO feeding decode; redirects flush and drop stale responses.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter int unsigned MAX_OUT  = 2,
    localparam int unsigned CW      = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [31:0]   imem_req_addr,
    input  logic          imem_resp_valid,
    input  logic [31:0]   imem_resp_data,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [31:0]   inst,
    output logic [31:0]   inst_pc,
    output logic [CW-1:0] queue_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam int unsigned TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned DW = 8;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [OW-1:0] out_q, out_d;
    logic [DW-1:0] drop_q, drop_d;
    logic [TW-1:0] tag_rd_q, tag_rd_d;
    logic [TW-1:0] tag_wr_q, tag_wr_d;

    logic [31:0] fifo_inst_q [DEPTH];
    logic [31:0] fifo_pc_q   [DEPTH];
    logic [31:0] tag_q       [MAX_OUT];

    logic [31:0] credit;
    logic        req_fire;
    logic        resp_wr;
    logic        resp_drop;
    logic        pop;

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
        return (32'(p) == MAX_OUT - 1) ? '0 : p + TW'(1);
    endfunction

    always_comb begin
        credit         = 32'(count_q) + 32'(out_q);
        imem_req_valid = reset && !redirect_valid
                         && (credit < DEPTH) && (32'(out_q) < MAX_OUT);
        imem_req_addr  = fetch_pc_q;
        inst_valid     = (count_q != '0);
        inst           = inst_valid ? fifo_inst_q[rd_ptr_q] : '0;
        inst_pc        = inst_valid ? fifo_pc_q[rd_ptr_q] : '0;
        queue_count    = count_q;
        req_fire       = imem_req_valid && imem_req_ready;
        pop            = inst_valid && inst_ready;
        resp_drop      = imem_resp_valid && (drop_q != '0);
        resp_wr        = imem_resp_valid && (drop_q == '0) && !redirect_valid;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        out_d      = out_q;
        drop_d     = drop_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;
        if (redirect_valid) begin
            // Tags of dropped requests are never read, so the tag FIFO only
            // ever holds live requests and is simply emptied here.
            fetch_pc_d = redirect_pc & ~32'd3;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            out_d      = '0;
            tag_rd_d   = '0;
            tag_wr_d   = '0;
            drop_d     = drop_q + DW'(out_q) - DW'(imem_resp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                tag_wr_d   = tag_next(tag_wr_q);
            end
            if (resp_drop) begin
                drop_d = drop_q - DW'(1);
            end
            if (resp_wr) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                tag_rd_d = tag_next(tag_rd_q);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            out_d   = out_q + OW'(req_fire) - OW'(resp_wr);
            count_d = count_q + CW'(resp_wr) - CW'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
        end
    end

    // Storage needs no reset: outputs are gated by count and tags by out.
    always_ff @(posedge clock) begin
        if (resp_wr) begin
            fifo_inst_q[wr_ptr_q] <= imem_resp_data;
            fifo_pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
        end
        if (req_fire) begin
            tag_q[tag_wr_q] <= fetch_pc_q;
        end
    end

    a_resp_owed: assert property (@(posedge clock) disable iff (!reset)
        imem_resp_valid |-> (32'(out_q) + 32'(drop_q)) != 0);

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        resp_wr |-> count_q != CW'(DEPTH));

endmodule
